// File: rtl/i2s_msb_receiver.sv
// -----------------------------------------------------------------------------
// i2s_msb_receiver
//
// Purpose:
//   Oversampled I2S-style serial receiver. The bit clock, data and running
//   flag are sampled with the 4x system clock. Every bit captured on a BCLK
//   rising edge is written to an external bit-addressed circular buffer of
//   2^CIRC_BUF_BITS frames of 256 bits each. The index of the most recently
//   completed frame is published on last_good_frame_idx_o.
//
// Configuration macro:
//   I2S_RX_IDLE_CLEAR_EN
//     Defined   : while not running, the idle address sweep covers the whole
//                 buffer with write enable high and data 0, clearing the RAM.
//     Undefined : the idle sweep covers 0x00..0xFF with write enable low.
//
// Ports:
//   clk_x4_i              in  system clock, about 4x BCLK, rising edge
//   rst_n_i               in  asynchronous active-low reset
//   i2s_running_i         in  asynchronous, high while the stream is valid
//   i2s_data_i            in  asynchronous serial data, MSB first
//   i2s_bclk_i            in  asynchronous bit clock
//   ram_write_addr_o      out bit address {frame_idx, bit_idx}
//   ram_write_en_o        out one-clock write strobe
//   ram_write_data_o      out bit to write
//   last_good_frame_idx_o out index of the last fully written frame
// -----------------------------------------------------------------------------
module i2s_msb_receiver #(
    parameter int CIRC_BUF_BITS = 3
) (
    input  logic                       clk_x4_i,
    input  logic                       rst_n_i,
    input  logic                       i2s_running_i,
    input  logic                       i2s_data_i,
    input  logic                       i2s_bclk_i,
    output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
    output logic                       ram_write_en_o,
    output logic                       ram_write_data_o,
    output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o
);

    localparam int AW = CIRC_BUF_BITS + 8;
    localparam logic [CIRC_BUF_BITS-1:0] FRAME_ONE = {{(CIRC_BUF_BITS-1){1'b0}}, 1'b1};

    // Two-flop synchronizers; bit [1] is the synchronized value.
    logic [1:0]               run_sync_r;
    logic [1:0]               data_sync_r;
    logic [1:0]               bclk_sync_r;
    logic                     bclk_prev_r;

    logic [7:0]               bit_idx_r;
    logic [CIRC_BUF_BITS-1:0] frame_idx_r;
    logic [CIRC_BUF_BITS-1:0] last_good_r;
    logic [AW-1:0]            addr_r;
    logic                     wr_en_r;
    logic                     wr_data_r;

    logic                     running_s;
    logic                     rise_s;
    logic [7:0]               bit_idx_nxt_s;
    logic [CIRC_BUF_BITS-1:0] frame_idx_nxt_s;
    logic [CIRC_BUF_BITS-1:0] last_good_nxt_s;
    logic [AW-1:0]            addr_nxt_s;
    logic                     wr_en_nxt_s;
    logic                     wr_data_nxt_s;

    assign running_s = run_sync_r[1];
    // Data and BCLK share the same synchronizer depth, so the synchronized
    // data bit is aligned with the detected rising edge.
    assign rise_s    = bclk_sync_r[1] & ~bclk_prev_r;

    // Synchronizer chains and BCLK edge-detector history.
    always_ff @(posedge clk_x4_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_sync_r  <= 2'b00;
            data_sync_r <= 2'b00;
            bclk_sync_r <= 2'b00;
            bclk_prev_r <= 1'b0;
        end else begin
            run_sync_r  <= {run_sync_r[0], i2s_running_i};
            data_sync_r <= {data_sync_r[0], i2s_data_i};
            bclk_sync_r <= {bclk_sync_r[0], i2s_bclk_i};
            bclk_prev_r <= bclk_sync_r[1];
        end
    end

    // Next-state logic for counters, frame bookkeeping and the write port.
    always_comb begin
        bit_idx_nxt_s   = bit_idx_r;
        frame_idx_nxt_s = frame_idx_r;
        last_good_nxt_s = last_good_r;
        addr_nxt_s      = addr_r;
        wr_en_nxt_s     = 1'b0;
        wr_data_nxt_s   = 1'b0;
        if (!running_s) begin
            // Idle: counters held at zero so the next run starts at address 0;
            // any partial frame is dropped and last_good is untouched.
            bit_idx_nxt_s   = 8'd0;
            frame_idx_nxt_s = {CIRC_BUF_BITS{1'b0}};
`ifdef I2S_RX_IDLE_CLEAR_EN
            addr_nxt_s      = addr_r + {{(AW-1){1'b0}}, 1'b1};
            wr_en_nxt_s     = 1'b1;
`else
            addr_nxt_s      = {{CIRC_BUF_BITS{1'b0}}, addr_r[7:0] + 8'd1};
            wr_en_nxt_s     = 1'b0;
`endif
        end else if (rise_s) begin
            addr_nxt_s    = {frame_idx_r, bit_idx_r};
            wr_en_nxt_s   = 1'b1;
            wr_data_nxt_s = data_sync_r[1];
            bit_idx_nxt_s = bit_idx_r + 8'd1;
            if (bit_idx_r == 8'd255) begin
                // Publish the frame on the same clock its last bit is written.
                frame_idx_nxt_s = frame_idx_r + FRAME_ONE;
                last_good_nxt_s = frame_idx_r;
            end else begin
                frame_idx_nxt_s = frame_idx_r;
            end
        end else begin
            addr_nxt_s = addr_r;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk_x4_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_idx_r   <= 8'd0;
            frame_idx_r <= {CIRC_BUF_BITS{1'b0}};
            last_good_r <= {CIRC_BUF_BITS{1'b0}};
            addr_r      <= {AW{1'b0}};
            wr_en_r     <= 1'b0;
            wr_data_r   <= 1'b0;
        end else begin
            bit_idx_r   <= bit_idx_nxt_s;
            frame_idx_r <= frame_idx_nxt_s;
            last_good_r <= last_good_nxt_s;
            addr_r      <= addr_nxt_s;
            wr_en_r     <= wr_en_nxt_s;
            wr_data_r   <= wr_data_nxt_s;
        end
    end

    assign ram_write_addr_o      = addr_r;
    assign ram_write_en_o        = wr_en_r;
    assign ram_write_data_o      = wr_data_r;
    assign last_good_frame_idx_o = last_good_r;

endmodule

// File: tb/tb_i2s_msb_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_msb_receiver
//
// Scoreboard bench for i2s_msb_receiver (CIRC_BUF_BITS = 3, BCLK period of
// eight system clocks). Every driven BCLK rising edge while running pushes
// the expected write (address, bit, due cycle) into a queue; the monitor pops
// and compares each write the DUT produces. A RAM image built from DUT writes
// is compared against the generated stream after a full 2048-bit run.
// -----------------------------------------------------------------------------
module tb_i2s_msb_receiver;

    localparam int CBB = 3;
    localparam int AW  = CBB + 8;
    localparam int NB  = 2048;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           running = 1'b0;
    logic           sdata = 1'b0;
    logic           bclk = 1'b1;
    logic [AW-1:0]  wr_addr;
    logic           wr_en;
    logic           wr_data;
    logic [CBB-1:0] last_good;

    typedef struct {
        logic [AW-1:0] addr;
        logic          bit_v;
        int            due;
    } exp_t;

    exp_t sb_q[$];
    logic ram_model [NB];
    logic stream_bits [NB];
    int   cyc = 0;
    int   bit_n = 0;
    int   exp_last = 0;
    int   frame_writes = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    i2s_msb_receiver #(.CIRC_BUF_BITS(CBB)) dut (
        .clk_x4_i              (clk),
        .rst_n_i               (rst_n),
        .i2s_running_i         (running),
        .i2s_data_i            (sdata),
        .i2s_bclk_i            (bclk),
        .ram_write_addr_o      (wr_addr),
        .ram_write_en_o        (wr_en),
        .ram_write_data_o      (wr_data),
        .last_good_frame_idx_o (last_good)
    );

    // System clock.
    always #5 clk = ~clk;

    // Cycle counter used to check write latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Write monitor: pops the scoreboard and records into the RAM image.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wr_en) begin
            if (sb_q.size() == 0) begin
`ifdef I2S_RX_IDLE_CLEAR_EN
                check_eq("idle_wdata", {31'd0, wr_data}, 32'd0);
                ram_model[wr_addr] = wr_data;
`else
                check_eq("spurious_write", {31'd0, wr_en}, 32'd0);
`endif
            end else begin
                e = sb_q.pop_front();
                check_eq("wr_addr", {21'd0, wr_addr}, {21'd0, e.addr});
                check_eq("wr_data", {31'd0, wr_data}, {31'd0, e.bit_v});
                check_eq("wr_latency", cyc, e.due);
                ram_model[wr_addr] = wr_data;
                frame_writes++;
                if (e.addr[7:0] == 8'hFF) begin
                    exp_last = int'(e.addr[AW-1:8]);
                    check_eq("frame_writes", frame_writes, 256);
                    frame_writes = 0;
                end
                check_eq("last_good", {29'd0, last_good}, exp_last);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run();
        @(negedge clk);
        running = 1'b1;
        bit_n = 0;
        frame_writes = 0;
        wait_clks(4);
    endtask

    task automatic stop_run();
        @(negedge clk);
        running = 1'b0;
        wait_clks(4);
    endtask

    // One BCLK period per bit: data changes with BCLK low, capture on rise.
    task automatic send_bits(input int n);
        exp_t e;
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            @(negedge clk);
            bclk = 1'b0;
            sdata = b;
            wait_clks(4);
            bclk = 1'b1;
            stream_bits[bit_n % NB] = b;
            e.addr  = AW'(bit_n % NB);
            e.bit_v = b;
            e.due   = cyc + 3;
            sb_q.push_back(e);
            bit_n++;
            wait_clks(3);
        end
    endtask

    // BCLK pulses that must not produce writes.
    task automatic idle_toggles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bclk = 1'b0;
            sdata = ~sdata;
            wait_clks(4);
            bclk = 1'b1;
            wait_clks(3);
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
        check_eq(tag, sb_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_addr"}, {21'd0, wr_addr}, 32'd0);
        check_eq({tag, "_en"}, {31'd0, wr_en}, 32'd0);
        check_eq({tag, "_data"}, {31'd0, wr_data}, 32'd0);
        check_eq({tag, "_last"}, {29'd0, last_good}, 32'd0);
    endtask

    initial begin
        int errs;
        for (int i = 0; i < NB; i++) ram_model[i] = 1'bx;

        // Reset state.
        wait_clks(4);
        check_outputs_zero("reset");

        // Idle sweep with BCLK held high.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            @(negedge clk);
`ifdef I2S_RX_IDLE_CLEAR_EN
            check_eq("idle_addr", {21'd0, wr_addr}, k % NB);
            check_eq("idle_en", {31'd0, wr_en}, 32'd1);
`else
            check_eq("idle_addr", {21'd0, wr_addr}, k % 256);
            check_eq("idle_en", {31'd0, wr_en}, 32'd0);
`endif
        end

`ifdef I2S_RX_IDLE_CLEAR_EN
        // Idle clearing must have zeroed the whole buffer.
        wait_clks(NB);
        errs = 0;
        for (int i = 0; i < NB; i++) if (ram_model[i] !== 1'b0) errs++;
        check_eq("idle_clear_errs", errs, 0);
`endif

        // Running but BCLK quiet: no writes expected.
        start_run();
        wait_clks(40);

        // Abort after 300 bits: frame 0 completes, frame 1 is dropped.
        send_bits(300);
        stop_run();
        drain("abort_drain");
        check_eq("abort_last_good", {29'd0, last_good}, 32'd0);

        // BCLK edges while not running are ignored.
        idle_toggles(10);
        check_eq("idle_toggle_q", sb_q.size(), 0);

        // Full 2048-bit run from address 0.
        for (int i = 0; i < NB; i++) ram_model[i] = 1'bx;
        start_run();
        send_bits(NB);
        drain("full_drain");
        errs = 0;
        for (int i = 0; i < NB; i++) if (ram_model[i] !== stream_bits[i]) errs++;
        check_eq("ram_content_errs", errs, 0);
        check_eq("full_last_good", {29'd0, last_good}, 32'd7);
        stop_run();
        wait_clks(NB);
        check_eq("full_last_good_idle", {29'd0, last_good}, 32'd7);

        // Short aborted run keeps the previous frame index.
        start_run();
        send_bits(100);
        stop_run();
        drain("short_drain");
        check_eq("short_last_good", {29'd0, last_good}, 32'd7);

        // Reset mid-stream with a write still in the synchronizer pipeline.
        start_run();
        send_bits(20);
        @(negedge clk);
        bclk = 1'b0;
        wait_clks(4);
        bclk = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        exp_last = 0;
        #1;
        check_outputs_zero("mid_reset");
        running = 1'b0;
        wait_clks(5);
        check_outputs_zero("mid_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        idle_toggles(5);
        start_run();
        send_bits(20);
        stop_run();
        drain("post_reset_drain");
        check_eq("post_reset_last_good", {29'd0, last_good}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
